// File: rtl/instr_controller.sv
// Multi-cycle control FSM for the 10-bit processor: latches an instruction on an
// Exec rising edge and sequences register-file, ALU and bus-select controls.
module instr_controller #(
  parameter int DW = 10,
  parameter int AW = 2
) (
  input  logic          Clkb,
  input  logic          Rstn,
  input  logic          Exec,
  input  logic [DW-1:0] INSTR,
  output logic [AW-1:0] WRA,
  output logic          ENW,
  output logic [AW-1:0] RDA0,
  output logic          ENR0,
  output logic [AW-1:0] RDA1,
  output logic          ENR1,
  output logic          ENA,
  output logic          ENC,
  output logic [1:0]    FN,
  output logic [1:0]    SEL,
  output logic          Busy,
  output logic          Done,
  output logic          Ill
);

  localparam logic [1:0] T0 = 2'd0;
  localparam logic [1:0] T1 = 2'd1;
  localparam logic [1:0] T2 = 2'd2;
  localparam logic [1:0] T3 = 2'd3;

  logic [1:0]    state;
  logic [1:0]    state_nxt;
  logic [DW-1:0] ir;
  logic          exec_q;
  logic          armed;
  logic          start;
  logic [AW-1:0] rx;
  logic [AW-1:0] ry;
  logic [3:0]    op;
  logic          is_alu;

  assign rx     = ir[9:8];
  assign ry     = ir[7:6];
  assign op     = ir[3:0];
  assign is_alu = (op >= 4'd2) && (op <= 4'd5);

  // Exec high across reset release is not an edge; it must be seen low first.
  assign start = Exec & ~exec_q & armed & (state == T0);

  always_ff @(posedge Clkb or negedge Rstn) begin
    if (!Rstn) begin
      state  <= T0;
      ir     <= '0;
      exec_q <= 1'b0;
      armed  <= 1'b0;
    end else begin
      state  <= state_nxt;
      exec_q <= Exec;
      armed  <= armed | ~Exec;
      if (start) ir <= INSTR;
    end
  end

  always_comb begin
    state_nxt = T0;
    case (state)
      T0:      state_nxt = start ? T1 : T0;
      T1:      state_nxt = is_alu ? T2 : T0;
      T2:      state_nxt = T3;
      T3:      state_nxt = T0;
      default: state_nxt = T0;
    endcase
  end

  always_comb begin
    WRA  = '0;
    ENW  = 1'b0;
    RDA0 = '0;
    ENR0 = 1'b0;
    RDA1 = '0;
    ENR1 = 1'b0;
    ENA  = 1'b0;
    ENC  = 1'b0;
    FN   = 2'b00;
    SEL  = 2'b00;
    Done = 1'b0;
    Ill  = 1'b0;
    case (state)
      T1: begin
        if (op == 4'd0) begin
          SEL  = 2'b01;
          ENW  = 1'b1;
          WRA  = rx;
          Done = 1'b1;
        end else if (op == 4'd1) begin
          ENR0 = 1'b1;
          RDA0 = ry;
          SEL  = 2'b10;
          ENW  = 1'b1;
          WRA  = rx;
          Done = 1'b1;
        end else if (is_alu) begin
          ENR0 = 1'b1;
          RDA0 = rx;
          ENA  = 1'b1;
        end else begin
          Ill  = 1'b1;
          Done = 1'b1;
        end
      end
      T2: begin
        ENR1 = 1'b1;
        RDA1 = ry;
        FN   = 2'(op - 4'd2);
        ENC  = 1'b1;
      end
      T3: begin
        SEL  = 2'b11;
        ENW  = 1'b1;
        WRA  = rx;
        Done = 1'b1;
      end
      default: ;
    endcase
  end

  assign Busy = (state != T0);

endmodule
